// File: rtl/sd_read_buffer_pkg.sv
// Shared types and widths for the SD read-side byte serializer.
package sd_read_buffer_pkg;

    localparam int ROW_W  = 13;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HI,
        LO
    } state_t;

endpackage

// File: rtl/sd_read_buffer_edge.sv
// NEXT_BYTE rising-edge detector.
// Build option: NEXT_BYTE_SYNC_EN adds a 2-flop synchronizer ahead of the
// detector for a consumer strobe that is asynchronous to the clock.
module sd_read_buffer_edge (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_next_byte,
    output logic o_nb_rise
);

    logic w_nb;
    logic r_nb_q;

`ifdef NEXT_BYTE_SYNC_EN
    logic [1:0] r_sync;

    // Two-stage synchronizer; reset to the live level so release never looks like an edge
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_sync <= {2{i_next_byte}};
        end else begin
            r_sync <= {r_sync[0], i_next_byte};
        end
    end

    assign w_nb = r_sync[1];
`else
    assign w_nb = i_next_byte;
`endif

    // Previous-level register; loaded with the current level in reset too
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_nb_q <= i_next_byte;
        end else begin
            r_nb_q <= w_nb;
        end
    end

    assign o_nb_rise = w_nb & ~r_nb_q;

endmodule

// File: rtl/sd_read_buffer.sv
// Read-side byte serializer: fetches 16-bit words from the memory controller
// while the read row trails the writer's row, and hands them out high byte
// first, one byte per NEXT_BYTE rising edge.
// Build option: NEXT_BYTE_SYNC_EN (synchronizer inside sd_read_buffer_edge).
module sd_read_buffer
    import sd_read_buffer_pkg::*;
#(
    parameter int WORDS_PER_ROW = 4,
    parameter int READ_LATENCY  = 2
) (
    input  logic              CLK_48MHZ,
    input  logic              RESET,
    input  logic              NEXT_BYTE,
    input  logic [WORD_W-1:0] DATA_READ,
    input  logic [ROW_W-1:0]  ROW_WRITE,
    output logic              READ_CMD,
    output logic [BYTE_W-1:0] BYTE_OUT
);

    localparam int WC_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(WORDS_PER_ROW - 1);
    localparam logic [3:0]      LAT_LAST = 4'(READ_LATENCY - 1);

    state_t              r_state,    w_state_next;
    logic [ROW_W-1:0]    r_rd_row,   w_rd_row_next;
    logic [WC_W-1:0]     r_word_cnt, w_word_cnt_next;
    logic [3:0]          r_lat_cnt,  w_lat_cnt_next;
    logic [WORD_W-1:0]   r_word,     w_word_next;
    logic                r_read_cmd, w_read_cmd_next;
    logic [BYTE_W-1:0]   r_byte_out, w_byte_out_next;

    logic w_nb_rise;
    logic w_avail;

    sd_read_buffer_edge u_edge (
        .i_clk       (CLK_48MHZ),
        .i_srst      (RESET),
        .i_next_byte (NEXT_BYTE),
        .o_nb_rise   (w_nb_rise)
    );

    // Ring buffer is non-empty whenever the read row has not caught the writer
    assign w_avail = (r_rd_row != ROW_WRITE);

    // Next-state, counter and datapath decode
    always_comb begin
        w_state_next    = r_state;
        w_rd_row_next   = r_rd_row;
        w_word_cnt_next = r_word_cnt;
        w_lat_cnt_next  = r_lat_cnt;
        w_word_next     = r_word;
        w_byte_out_next = r_byte_out;

        case (r_state)
            IDLE: begin
                if (w_avail) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                w_lat_cnt_next = 4'd0;
                w_state_next   = WAIT;
            end
            WAIT: begin
                // lat_cnt counts completed wait cycles; capture on the last one
                if (r_lat_cnt == LAT_LAST) begin
                    w_word_next     = DATA_READ;
                    w_byte_out_next = DATA_READ[WORD_W-1:BYTE_W];
                    w_state_next    = HI;
                end else begin
                    w_lat_cnt_next = r_lat_cnt + 4'd1;
                end
            end
            HI: begin
                if (w_nb_rise) begin
                    w_byte_out_next = r_word[BYTE_W-1:0];
                    w_state_next    = LO;
                end
            end
            LO: begin
                if (w_nb_rise) begin
                    if (r_word_cnt == WC_LAST) begin
                        w_word_cnt_next = '0;
                        w_rd_row_next   = r_rd_row + 13'd1;
                    end else begin
                        w_word_cnt_next = r_word_cnt + WC_W'(1);
                    end
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Only IDLE leads to REQ, so this is a single-cycle pulse
        w_read_cmd_next = (w_state_next == REQ);
    end

    // State and datapath registers
    always_ff @(posedge CLK_48MHZ) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_rd_row   <= '0;
            r_word_cnt <= '0;
            r_lat_cnt  <= '0;
            r_word     <= '0;
            r_read_cmd <= 1'b0;
            r_byte_out <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rd_row   <= w_rd_row_next;
            r_word_cnt <= w_word_cnt_next;
            r_lat_cnt  <= w_lat_cnt_next;
            r_word     <= w_word_next;
            r_read_cmd <= w_read_cmd_next;
            r_byte_out <= w_byte_out_next;
        end
    end

    assign READ_CMD = r_read_cmd;
    assign BYTE_OUT = r_byte_out;

endmodule

// File: tb/tb_sd_read_buffer.sv
// Scoreboard bench for sd_read_buffer: stimulus tasks push expected READ_CMD
// cycles and expected BYTE_OUT values/cycles; a monitor pops and compares.
module tb_sd_read_buffer;

    localparam int L    = 2;
    localparam int WPR  = 4;
    localparam int HOLD = 20;
`ifdef NEXT_BYTE_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    localparam int M_EMPTY = 0;
    localparam int M_HI    = 1;
    localparam int M_LO    = 2;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        NEXT_BYTE = 1'b0;
    logic [15:0] DATA_READ = 16'hFF00;
    logic [12:0] ROW_WRITE = 13'h000F;
    logic        READ_CMD;
    logic [7:0]  BYTE_OUT;

    always #10 clk = ~clk;

    sd_read_buffer #(.WORDS_PER_ROW(WPR), .READ_LATENCY(L)) dut (
        .CLK_48MHZ (clk),
        .RESET     (RESET),
        .NEXT_BYTE (NEXT_BYTE),
        .DATA_READ (DATA_READ),
        .ROW_WRITE (ROW_WRITE),
        .READ_CMD  (READ_CMD),
        .BYTE_OUT  (BYTE_OUT)
    );

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } exp_byte_t;

    // Word returned for the n-th read command (mod 16); adjacent bytes all differ
    logic [15:0] mem [16] = '{16'hFF00, 16'hA55A, 16'h1234, 16'h5678,
                              16'h9ABC, 16'hDEF0, 16'h0F1E, 16'h2D3C,
                              16'h4B5A, 16'h6978, 16'h8796, 16'hA5B4,
                              16'hC3D2, 16'hE1F0, 16'h1357, 16'h2468};

    int        cmd_q[$];
    exp_byte_t byte_q[$];
    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;
    bit        mon_en = 1'b0;
    logic      prev_cmd = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    int        n_cmd = 0;

    int          m_row = 0;
    int          m_wcnt = 0;
    int          m_st = M_EMPTY;
    int          widx = 0;
    logic [15:0] cur_word = 16'h0000;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory controller: data valid only during the READ_LATENCY-th cycle after READ_CMD
    initial begin
        logic [15:0] hist;
        logic [15:0] pend;
        int          ridx;
        hist = '0;
        pend = '0;
        ridx = 0;
        forever begin
            @(negedge clk);
            hist = {hist[14:0], READ_CMD};
            if (READ_CMD) begin
                pend = mem[ridx % 16];
                ridx++;
            end
            DATA_READ = hist[L] ? pend : (RESET ? 16'hFF00 : 16'hC3C3);
        end
    end

    // Monitor: compares every READ_CMD pulse and every BYTE_OUT change
    initial forever begin
        exp_byte_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (READ_CMD) begin
                checks++;
                if (cmd_q.size() == 0 || cmd_q[0] != cyc) begin
                    errors++;
                    $display("FAIL read_cmd_time: pulse at cycle %0d, expected cycle %0d",
                             cyc, (cmd_q.size() != 0) ? cmd_q[0] : -1);
                end else begin
                    void'(cmd_q.pop_front());
                    $display("ok   read_cmd pulse at cycle %0d", cyc);
                end
                checks++;
                if (prev_cmd) begin
                    errors++;
                    $display("FAIL read_cmd_width: READ_CMD high at cycles %0d and %0d, required single cycle",
                             cyc - 1, cyc);
                end
            end
            while (cmd_q.size() != 0 && cmd_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL read_cmd_missing: no pulse at cycle %0d (now %0d)", cmd_q[0], cyc);
                void'(cmd_q.pop_front());
            end
            if (BYTE_OUT !== prev_byte) begin
                checks++;
                if (byte_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte_unexpected: BYTE_OUT %02h -> %02h at cycle %0d, required no change",
                             prev_byte, BYTE_OUT, cyc);
                end else begin
                    e = byte_q.pop_front();
                    if (e.b !== BYTE_OUT || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL byte_out: got %02h at cycle %0d, required %02h at cycle %0d",
                                 BYTE_OUT, cyc, e.b, e.cyc);
                    end else begin
                        $display("ok   byte_out %02h at cycle %0d", BYTE_OUT, cyc);
                    end
                end
            end
            while (byte_q.size() != 0 && byte_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL byte_missing: %02h due at cycle %0d not seen (now %0d)",
                         byte_q[0].b, byte_q[0].cyc, cyc);
                void'(byte_q.pop_front());
            end
        end
        if (READ_CMD) n_cmd++;
        prev_cmd  = READ_CMD;
        prev_byte = BYTE_OUT;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // DUT enters/sits in IDLE during cycle i with data available
    task automatic push_fetch(input int i);
        exp_byte_t e;
        cmd_q.push_back(i + 1);
        e.cyc = i + L + 2;
        e.b   = mem[widx % 16][15:8];
        byte_q.push_back(e);
        cur_word = mem[widx % 16];
        widx++;
        m_st = M_HI;
    endtask

    task automatic do_rise();
        exp_byte_t e;
        int c;
        @(negedge clk);
        NEXT_BYTE = 1'b1;
        c = cyc;
        if (m_st == M_HI) begin
            e.cyc = c + 1 + D;
            e.b   = cur_word[7:0];
            byte_q.push_back(e);
            m_st = M_LO;
        end else if (m_st == M_LO) begin
            if (m_wcnt == WPR - 1) begin
                m_wcnt = 0;
                m_row  = (m_row + 1) % 8192;
            end else begin
                m_wcnt++;
            end
            if (m_row != int'(ROW_WRITE)) push_fetch(c + 1 + D);
            else m_st = M_EMPTY;
        end
        repeat (HOLD) @(negedge clk);
        NEXT_BYTE = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic set_rw(input logic [12:0] v);
        @(negedge clk);
        ROW_WRITE = v;
        if (m_st == M_EMPTY && m_row != int'(v)) push_fetch(cyc);
    endtask

    task automatic do_reset(input logic [12:0] rw, input logic nb, input int ncyc);
        @(negedge clk);
        mon_en    = 1'b0;
        RESET     = 1'b1;
        ROW_WRITE = rw;
        NEXT_BYTE = nb;
        cmd_q.delete();
        byte_q.delete();
        @(negedge clk);
        check("reset_read_cmd", int'(READ_CMD), 0);
        check("reset_byte_out", int'(BYTE_OUT), 0);
        repeat (ncyc) @(negedge clk);
        RESET  = 1'b0;
        m_row  = 0;
        m_wcnt = 0;
        m_st   = M_EMPTY;
        mon_en = 1'b1;
        if (rw != 13'd0) push_fetch(cyc);
    endtask

    task automatic check_drained(input string name);
        repeat (L + 8) @(negedge clk);
        check(name, cmd_q.size() + byte_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset with rows available, then consume four words
        do_reset(13'h000F, 1'b0, 3);
        repeat (HOLD) @(negedge clk);
        repeat (8) do_rise();
        check_drained("basic_drained");

        // Empty after reset, then writer advances one row
        do_reset(13'h0000, 1'b0, 3);
        base = n_cmd;
        repeat (1000) @(negedge clk);
        check("empty_read_cmds", n_cmd - base, 0);
        check("empty_byte_out", int'(BYTE_OUT), 0);
        set_rw(13'h0001);
        repeat (HOLD) @(negedge clk);
        repeat (8) do_rise();
        repeat (200) @(negedge clk);
        check("row1_read_cmds", n_cmd - base, 4);
        check_drained("row1_drained");

        // Writer advances again: reads resume for another row
        base = n_cmd;
        set_rw(13'h0002);
        repeat (HOLD) @(negedge clk);
        repeat (8) do_rise();
        repeat (200) @(negedge clk);
        check("row2_read_cmds", n_cmd - base, 4);
        check_drained("row2_drained");

        // Wrap-around: read row at 0x1FFF, writer at 0x000
        base = n_cmd;
        @(negedge clk);
        force dut.r_rd_row = 13'h1FFF;
        ROW_WRITE = 13'h0000;
        m_row = 8191;
        push_fetch(cyc);
        @(negedge clk);
        release dut.r_rd_row;
        repeat (HOLD) @(negedge clk);
        repeat (8) do_rise();
        repeat (200) @(negedge clk);
        check("wrap_read_cmds", n_cmd - base, 4);
        check_drained("wrap_drained");

        // Reset while a read is in flight, NEXT_BYTE held high across release
        set_rw(13'h0005);
        @(negedge clk);
        do_reset(13'h0005, 1'b1, 2);
        repeat (100) @(negedge clk);
        check("no_advance_byte_out", int'(BYTE_OUT), int'(cur_word[15:8]));
        check_drained("midreset_drained");
        NEXT_BYTE = 1'b0;
        repeat (HOLD) @(negedge clk);
        do_rise();
        check_drained("final_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_read_buffer.md
Name: sd_read_buffer

Overview:
- Read-side byte serializer between the memory controller and a byte-oriented downlink/consumer.
- Tracks an internal 13-bit read-row pointer against the writer's current row (ROW_WRITE) and requests 16-bit words with a one-cycle READ_CMD pulse.
- Presents each word as two bytes on BYTE_OUT, high byte first, advancing on NEXT_BYTE rising edges.

Parameters:
- WORDS_PER_ROW, 4: 16-bit words consumed per row before the read-row pointer increments (power of two, 1..256).
- READ_LATENCY, 2: clock cycles from the READ_CMD cycle to DATA_READ valid (1..15).

Ports:
- CLK_48MHZ  in  1  system clock, 48 MHz; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- NEXT_BYTE  in  1  consumer advance strobe; each rising edge requests the next byte.
- DATA_READ  in  16  word returned by the memory controller, valid READ_LATENCY cycles after READ_CMD.
- ROW_WRITE  in  13  writer's current row pointer (first row not yet written).
- READ_CMD  out  1  registered, one-cycle read request pulse.
- BYTE_OUT  out  8  current output byte, registered.

Behaviour:
- Reset (RESET=1 at a clock edge): state=IDLE; rd_row=0; word_cnt=0; lat_cnt=0; word_reg=0; READ_CMD=0; BYTE_OUT=0x00; edge register nb_q<=NEXT_BYTE, so no spurious edge at reset release. Reset mid-operation aborts any pending request; captured data is discarded.
- Edge detect: nb_rise = NEXT_BYTE & ~nb_q; nb_q<=NEXT_BYTE every cycle.
- Available = (rd_row != ROW_WRITE), 13-bit equality compare. Ring semantics: rd_row wraps 8191->0.
- IDLE: if available -> REQ, else stay. BYTE_OUT holds its last value.
- REQ: READ_CMD=1 for exactly this one cycle; lat_cnt<=0; -> WAIT.
- WAIT: count READ_LATENCY cycles after the REQ cycle. On the edge ending the READ_LATENCY-th cycle: word_reg<=DATA_READ; BYTE_OUT<=DATA_READ[15:8]; -> HI.
- HI: on nb_rise, BYTE_OUT<=word_reg[7:0]; -> LO.
- LO: on nb_rise:
  - If word_cnt==WORDS_PER_ROW-1: word_cnt<=0 and rd_row<=rd_row+1 (mod 8192).
  - Else word_cnt<=word_cnt+1.
  - -> IDLE. The next READ_CMD therefore occurs 2 cycles after that edge, if data is available.
- nb_rise in IDLE/REQ/WAIT is ignored; no pending flag.
- ROW_WRITE may change at any time. Only IDLE samples it; an in-flight word always completes.
- Empty (rd_row==ROW_WRITE): no READ_CMD. Output holds the low byte of the last word, or 0x00 after reset.
- READ_CMD is never asserted in consecutive cycles.

Optional Feature:
- Macro NEXT_BYTE_SYNC_EN.
- Defined: NEXT_BYTE passes through a 2-flop synchronizer before edge detect. All NEXT_BYTE-to-BYTE_OUT responses are delayed by 2 extra cycles. Synchronizer flops reset to the NEXT_BYTE level.
- Undefined: NEXT_BYTE is assumed synchronous to CLK_48MHZ and used directly; response is 1 cycle after the sampling edge.

Decomposition:
- Package sd_read_buffer_pkg:
  - state enum {IDLE, REQ, WAIT, HI, LO};
  - ROW_W=13, WORD_W=16, BYTE_W=8 localparams.
- One natural sub-module: sd_read_buffer_edge, containing the optional synchronizer and the rising-edge detector. The FSM, counters and datapath stay in the top module.

Test Plan:
- Reset with ROW_WRITE=0x000F, DATA_READ=0xFF00 -> READ_CMD=0, BYTE_OUT=0x00 during reset. First READ_CMD pulse, one cycle wide, on the 2nd edge after release. BYTE_OUT=0xFF READ_LATENCY cycles later.
- Toggle NEXT_BYTE every 100 cycles -> first rise: BYTE_OUT=0x00. Second rise: new READ_CMD pulse 2 cycles later, then BYTE_OUT=0xFF. Falling edges cause no change.
- Empty: ROW_WRITE=0x000 after reset -> READ_CMD stays 0 and BYTE_OUT stays 0x00 for 1000 cycles. Setting ROW_WRITE=0x001 -> READ_CMD pulse within 2 cycles.
- Row exhaustion: ROW_WRITE=0x001, consume 4 words (8 rises) -> exactly 4 READ_CMD pulses, then none. Setting ROW_WRITE=0x002 resumes reads.
- Wrap-around: force rd_row to 0x1FFF with ROW_WRITE=0x000 -> reads continue; after 4 words rd_row=0x000 and reads stop.
- Mid-operation reset: assert RESET during WAIT -> next edge READ_CMD=0, BYTE_OUT=0x00, state=IDLE. A NEXT_BYTE already high at release produces no advance.
